// File: rtl/ps2_rx_controller.sv
// ps2_rx_controller
// Receives 11-bit PS/2 device-to-host frames (start, 8 data LSB first, parity,
// stop) from debounced kclk/kdata lines and presents each good byte on a
// valid/ready output. Bad or stalled frames pulse frame_err; a good byte that
// arrives while the previous one is still undelivered is dropped with an
// overrun pulse.
//
// Optional build macro: PS2_PARITY_CHECK_EN
//   defined   - parity bit checked as odd parity over the data byte; a
//               mismatch is reported as frame_err and the byte is not delivered.
//   undefined - parity bit is clocked past and ignored; only the stop bit
//               decides frame validity.

module ps2_rx_controller #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kclk,
    input  logic       kdata,
    output logic [7:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Idle counter is at least 15 bits wide, wider only if the timeout needs it.
    localparam int IDLE_W = ($clog2(TIMEOUT_CYCLES) > 15) ? $clog2(TIMEOUT_CYCLES) : 15;
    localparam logic [IDLE_W-1:0] TIMEOUT_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Synchroniser and edge-detect flops. They reset to 1 because both PS/2
    // lines idle high, so release from reset never looks like a falling edge.
    logic kclk_meta;
    logic kclk_sync;
    logic kclk_prev;
    logic kdata_meta;
    logic kdata_sync;

    // Frame receiver state.
    logic [1:0]        state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic [IDLE_W-1:0] idle_cnt;

    // Per-cycle events derived from the receiver state.
    logic kclk_fall;
    logic timeout;
    logic parity_ok;
    logic frame_good;
    logic frame_bad;

    // Two-flop synchronisers on both lines plus one delayed copy of kclk.
    // NOTE: every clocked block uses non-blocking assignments so the flops
    // update together and the chain really is three stages, not one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kclk_meta  <= 1'b1;
            kclk_sync  <= 1'b1;
            kclk_prev  <= 1'b1;
            kdata_meta <= 1'b1;
            kdata_sync <= 1'b1;
        end else begin
            kclk_meta  <= kclk;
            kclk_sync  <= kclk_meta;
            kclk_prev  <= kclk_sync;
            kdata_meta <= kdata;
            kdata_sync <= kdata_meta;
        end
    end

    assign kclk_fall = kclk_prev & ~kclk_sync;

    // A stalled frame times out only on a cycle with no falling edge, so a
    // late-but-valid edge landing on the last allowed cycle still wins.
    assign timeout = (state != S_IDLE) && !kclk_fall && (idle_cnt == TIMEOUT_LAST);

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;

    // Captures the parity bit so it can be checked when the stop bit arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit <= 1'b0;
        end else if ((state == S_PARITY) && kclk_fall) begin
            parity_bit <= kdata_sync;
        end
    end

    // Odd parity: data plus parity bit must hold an odd number of ones.
    assign parity_ok = ^{shift_reg, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    assign frame_good = (state == S_STOP) && kclk_fall &&  (kdata_sync && parity_ok);
    assign frame_bad  = (state == S_STOP) && kclk_fall && !(kdata_sync && parity_ok);

    // Frame FSM: start bit, eight data bits LSB first, parity, stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    // A falling edge with data high is line noise, not a start bit.
                    if (kclk_fall && !kdata_sync) begin
                        state   <= S_DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (kclk_fall) begin
                        shift_reg <= {kdata_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (kclk_fall) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (kclk_fall) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Abandon the partial frame when the keyboard clock stalls.
            if (timeout) begin
                state <= S_IDLE;
            end
        end
    end

    // Inter-edge watchdog: runs only inside a frame, cleared by every kclk fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((state == S_IDLE) || kclk_fall || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Output register with valid/ready hand-off and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= frame_bad | timeout;
            overrun   <= 1'b0;
            if (frame_good) begin
                // The slot is free if empty or being emptied this very cycle.
                if (!code_valid || code_ready) begin
                    code       <= shift_reg;
                    code_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (code_valid && code_ready) begin
                code_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_rx_controller.sv
// tb_ps2_rx_controller
// Directed frames with hand-computed expected bytes. Stimulus pushes expected
// codes into a scoreboard queue; a monitor pops and compares on every
// delivery handshake and counts frame_err/overrun pulses.

module tb_ps2_rx_controller;

    localparam int TIMEOUT = 300;
    localparam int HALF    = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       kclk;
    logic       kdata;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic [7:0] exp_q[$];
    int         total  = 0;
    int         passed = 0;
    int         exp_err = 0;
    int         exp_ovr = 0;
    int         seen_err = 0;
    int         seen_ovr = 0;

    ps2_rx_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kclk       (kclk),
        .kdata      (kdata),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] data, input logic par, input logic stop);
        return {stop, par, data, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        kdata = b;
        wait_clk(HALF);
        kclk = 1'b0;
        wait_clk(HALF);
        kclk = 1'b1;
    endtask

    task automatic send_partial(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) send_bit(f[i]);
        wait_clk(HALF);
    endtask

    // mode 0: plain; 1: check 3-cycle latency and 1-cycle valid;
    // 2: raise code_ready exactly in the cycle the frame completes.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop, input int mode);
        logic [10:0] f;
        f = mk_frame(data, par, stop);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        kdata = f[10];
        wait_clk(HALF);
        kclk = 1'b0;
        if (mode == 1) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("latency_not_early", code_valid, 0);
            @(posedge clk);
            @(negedge clk);
            check("latency_valid", code_valid, 1);
            check("latency_code", code, data);
            check("busy_after_stop", busy, 0);
            @(negedge clk);
            check("valid_one_cycle", code_valid, 0);
        end else if (mode == 2) begin
            repeat (2) @(posedge clk);
            #1;
            code_ready = 1'b1;
        end
        wait_clk(HALF);
        kclk = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Scoreboard monitor.
    initial begin : monitor
        logic prev_err;
        logic prev_ovr;
        prev_err = 1'b0;
        prev_ovr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (code_valid && code_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL sb_unexpected: got code %0h expected no delivery", code);
                    end else begin
                        check("sb_code", code, exp_q.pop_front());
                    end
                end
                if (frame_err) begin
                    seen_err++;
                    check("frame_err_pulse_width", prev_err, 0);
                end
                if (overrun) begin
                    seen_ovr++;
                    check("overrun_pulse_width", prev_ovr, 0);
                end
            end
            prev_err = frame_err;
            prev_ovr = overrun;
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n = 1'b0;
        kclk = 1'b1;
        kdata = 1'b1;
        code_ready = 1'b0;
        #12;
        check("rst_code", code, 8'h00);
        check("rst_valid", code_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", frame_err, 0);
        check("rst_ovr", overrun, 0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);

        // Basic frame with latency and single-cycle valid.
        code_ready = 1'b1;
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 1);

        // Wrong parity bit.
`ifdef PS2_PARITY_CHECK_EN
        exp_err++;
`else
        exp_q.push_back(8'h1C);
`endif
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        check("parity_err_count", seen_err, exp_err);

        // Overrun: second good frame dropped while first is held.
        code_ready = 1'b0;
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        exp_ovr++;
        send_frame(8'hF0, 1'b1, 1'b1, 0);
        check("overrun_code_held", code, 8'h1C);
        check("overrun_valid_held", code_valid, 1);
        check("overrun_count", seen_ovr, exp_ovr);
        code_ready = 1'b1;
        wait_clk(2);
        check("overrun_accepted", code_valid, 0);

        // Timeout after start bit plus four data bits.
        send_partial(mk_frame(8'h55, 1'b1, 1'b1), 5);
        check("timeout_busy_mid", busy, 1);
        exp_err++;
        wait_clk(TIMEOUT + 20);
        check("timeout_busy_after", busy, 0);
        check("timeout_err_count", seen_err, exp_err);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, 1'b1, 0);

        // Reset mid-frame.
        send_partial(mk_frame(8'h1C, 1'b0, 1'b1), 6);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_code", code, 8'h00);
        check("midrst_valid", code_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", frame_err, 0);
        check("midrst_ovr", overrun, 0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 0);

        // Bad stop bit.
        exp_err++;
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        check("stop_err_no_valid", code_valid, 0);
        check("stop_err_count", seen_err, exp_err);

        // Accept in the same cycle a new frame completes.
        code_ready = 1'b0;
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, 1'b1, 2);
        wait_clk(5);
        check("same_cycle_drained", code_valid, 0);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_err_count", seen_err, exp_err);
        check("final_ovr_count", seen_ovr, exp_ovr);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
